// File: rtl/scan_decoder.sv
// One-hot decoder with a direct mode (decode sel on in_valid) and an auto-scan
// mode that walks every output, holding each for DWELL cycles.
module scan_decoder #(
  parameter  int SEL_W = 3,
  parameter  int DWELL = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] scan_idx,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t           state_q, state_d;
  logic             last_scan_q, last_scan_d;
  logic [15:0]      dwell_q, dwell_d;
  logic [SEL_W-1:0] idx_q, idx_d, idx_inc;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q, wrap_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign idx_inc = idx_q + SEL_W'(1);

  always_comb begin
    state_d     = ST_OFF;
    last_scan_d = last_scan_q;
    dwell_d     = dwell_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    wrap_d      = 1'b0;

    if (en) begin
      state_d = mode ? ST_SCAN : ST_DIRECT;
    end

    case (state_d)
      ST_DIRECT: begin
        last_scan_d = 1'b0;
        if (in_valid) begin
          out_d       = onehot(sel);
          idx_d       = sel;
          out_valid_d = 1'b1;
        end else if (state_q != ST_DIRECT) begin
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        last_scan_d = 1'b1;
        out_valid_d = 1'b1;
        // Scan restarts only when DIRECT was the last active mode; a pause
        // through OFF resumes by re-showing the frozen index for one cycle.
        if (state_q == ST_DIRECT || (state_q == ST_OFF && !last_scan_q)) begin
          idx_d   = '0;
          dwell_d = '0;
          out_d   = onehot('0);
        end else if (state_q == ST_OFF) begin
          out_d = onehot(idx_q);
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          idx_d   = idx_inc;
          out_d   = onehot(idx_inc);
          wrap_d  = (idx_q == '1);
        end else begin
          dwell_d = dwell_q + 16'd1;
          out_d   = onehot(idx_q);
        end
      end
      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      last_scan_q <= 1'b0;
      dwell_q     <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_scan_q <= last_scan_d;
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign scan_idx  = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: an 8-output instance (DWELL=2) and a
// 4-output instance (DWELL=1) sharing clock and control inputs.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, in_valid;
  logic [2:0] sel;
  logic [1:0] sel_b;
  logic [7:0] out_a;
  logic       ov_a, wrap_a;
  logic [2:0] idx_a;
  logic [3:0] out_b;
  logic       ov_b, wrap_b;
  logic [1:0] idx_b;

  assign sel_b = sel[1:0];

  scan_decoder #(.SEL_W(3), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .sel(sel),
    .out(out_a), .out_valid(ov_a), .scan_idx(idx_a), .wrap(wrap_a)
  );

  scan_decoder #(.SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .sel(sel_b),
    .out(out_b), .out_valid(ov_b), .scan_idx(idx_b), .wrap(wrap_b)
  );

  // Expected words are {out_valid, wrap, scan_idx, out}.
  logic [12:0] exp_q[$];
  logic [12:0] msk_q[$];
  string       tag_q[$];
  logic [7:0]  exp_b_q[$];
  string       tag_b_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic v, input logic [2:0] s);
    rst = r; en = e; mode = m; in_valid = v; sel = s;
  endtask

  task automatic expect_a(input string tag, input logic ov, input logic w,
                          input logic [2:0] idx, input logic [7:0] o,
                          input logic chk_idx);
    exp_q.push_back({ov, w, idx, o});
    msk_q.push_back({2'b11, (chk_idx ? 3'b111 : 3'b000), 8'hff});
    tag_q.push_back(tag);
  endtask

  task automatic expect_b(input string tag, input logic ov, input logic w,
                          input logic [1:0] idx, input logic [3:0] o);
    exp_b_q.push_back({ov, w, idx, o});
    tag_b_q.push_back(tag);
  endtask

  task automatic cycle();
    logic [12:0] e, m, obs;
    logic [7:0]  eb, obs_b;
    string       t;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      m   = msk_q.pop_front();
      t   = tag_q.pop_front();
      obs = {ov_a, wrap_a, idx_a, out_a};
      n_tests++;
      assert ((obs & m) === (e & m)) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs & m, e & m);
      end
    end
    while (exp_b_q.size() > 0) begin
      eb    = exp_b_q.pop_front();
      t     = tag_b_q.pop_front();
      obs_b = {ov_b, wrap_b, idx_b, out_b};
      n_tests++;
      assert (obs_b === eb) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs_b, eb);
      end
    end
  endtask

  initial begin
    logic [2:0] ix;
    logic [1:0] ixb;

    // Reset overrides active inputs on every cycle it is held.
    drive(1, 1, 1, 1, 3'd5);
    for (int k = 0; k < 2; k++) begin
      expect_a("reset_a", 0, 0, 3'd0, 8'h00, 1);
      expect_b("reset_b", 0, 0, 2'd0, 4'h0);
      cycle();
    end

    // Direct sweep, decode visible one cycle after the edge.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 3'(i));
      expect_a("direct_sweep", 1, 0, 3'(i), 8'h01 << i, 1);
      cycle();
    end

    drive(0, 1, 0, 0, 3'd2);
    expect_a("direct_hold", 1, 0, 3'd7, 8'h80, 1);
    cycle();

    drive(0, 0, 0, 1, 3'd5);
    expect_a("disable", 0, 0, 3'd7, 8'h00, 1);
    cycle();

    drive(0, 1, 0, 0, 3'd5);
    for (int k = 0; k < 2; k++) begin
      expect_a("reenable_no_valid", 0, 0, 3'd0, 8'h00, 0);
      cycle();
    end

    drive(0, 1, 0, 1, 3'd3);
    expect_a("reenable_valid", 1, 0, 3'd3, 8'h08, 1);
    cycle();

    // Scan from DIRECT restarts at 0; 17th cycle wraps; stop at idx 3, dwell 1.
    drive(0, 1, 1, 0, 3'd0);
    for (int k = 1; k <= 24; k++) begin
      ix = 3'(((k - 1) / 2) % 8);
      expect_a("scan", 1, (k == 17), ix, 8'h01 << ix, 1);
      cycle();
    end

    drive(0, 0, 1, 0, 3'd0);
    for (int k = 0; k < 5; k++) begin
      expect_a("pause", 0, 0, 3'd3, 8'h00, 1);
      cycle();
    end

    // Resume shows the frozen index once, then the remaining dwell runs out.
    drive(0, 1, 1, 0, 3'd0);
    expect_a("resume_0", 1, 0, 3'd3, 8'h08, 1); cycle();
    expect_a("resume_1", 1, 0, 3'd4, 8'h10, 1); cycle();
    expect_a("resume_2", 1, 0, 3'd4, 8'h10, 1); cycle();
    expect_a("resume_3", 1, 0, 3'd5, 8'h20, 1); cycle();
    expect_a("resume_4", 1, 0, 3'd5, 8'h20, 1); cycle();
    expect_a("resume_5", 1, 0, 3'd6, 8'h40, 1); cycle();

    drive(1, 1, 1, 0, 3'd0);
    expect_a("reset_midscan", 0, 0, 3'd0, 8'h00, 1);
    cycle();

    drive(0, 1, 1, 0, 3'd0);
    expect_a("scan_after_reset", 1, 0, 3'd0, 8'h01, 1);
    cycle();

    drive(0, 1, 0, 1, 3'd6);
    expect_a("scan_to_direct", 1, 0, 3'd6, 8'h40, 1);
    cycle();

    // Narrow instance with DWELL=1 advances every scan cycle.
    drive(1, 0, 0, 0, 3'd0);
    expect_b("reset_b2", 0, 0, 2'd0, 4'h0);
    cycle();
    drive(0, 1, 1, 0, 3'd0);
    for (int k = 1; k <= 5; k++) begin
      ixb = 2'((k - 1) % 4);
      expect_b("scan_dwell1", 1, (k == 5), ixb, 4'h1 << ixb);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3: select width; output width OUT_W = 2**SEL_W (derived, not overridable).
REQ-002 Parameter DWELL, default 4: cycles each output is held in scan mode; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  block enable; 0 forces outputs to zero.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 in_valid  input  1  qualifies sel in direct mode.
REQ-008 sel  input  SEL_W  index to decode in direct mode.
REQ-009 out  output  OUT_W  registered one-hot (or all-zero) decode result.
REQ-010 out_valid  output  1  high when out carries a valid one-hot value.
REQ-011 scan_idx  output  SEL_W  registered index currently driven on out.
REQ-012 wrap  output  1  one-cycle pulse when scan index wraps from OUT_W-1 to 0.

Function
REQ-013 The block SHALL implement a 3-state FSM: OFF, DIRECT, SCAN; all outputs registered, no combinational input-to-output path.
REQ-014 Next state, evaluated every cycle: en=0 -> OFF; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
REQ-015 OFF: out=0, out_valid=0, wrap=0; scan_idx and dwell counter frozen at current values.
REQ-016 DIRECT: en=1, mode=0, in_valid=1 at edge N -> out=one-hot(sel), scan_idx=sel, out_valid=1 after edge N (latency 1 cycle).
REQ-017 DIRECT with in_valid=0: out, scan_idx, out_valid hold previous values.
REQ-018 Entry into DIRECT from SCAN or OFF: out=0, out_valid=0 until the first in_valid=1 cycle; if in_valid=1 on the entry cycle, decode takes effect on that same edge.
REQ-019 SCAN: sel and in_valid ignored; out=one-hot(scan_idx), out_valid=1.
REQ-020 SCAN: internal dwell counter counts 0..DWELL-1; on reaching DWELL-1 it returns to 0 and scan_idx increments by 1.
REQ-021 Wrap-around: increment from OUT_W-1 SHALL yield 0 and assert wrap for exactly that one cycle (coincident with out=one-hot(0)).
REQ-022 Entry into SCAN from DIRECT: scan_idx=0, dwell=0, out=one-hot(0) on the first SCAN edge; no wrap pulse.
REQ-023 Entry into SCAN from OFF (resume): scan_idx and dwell continue from frozen values; pause does not restart the dwell.
REQ-024 DWELL=1: scan_idx advances every cycle in SCAN.
REQ-025 Dwell counter width SHALL be 16 bits; SEL_W up to 8 supported.
REQ-026 Simultaneous mode and en change resolves per REQ-014 on the same edge; last-active-state distinction (DIRECT vs OFF) SHALL be tracked for REQ-022/023.

Reset
REQ-027 rst=1 at an edge SHALL override all inputs: state=OFF, out=0, out_valid=0, scan_idx=0, dwell=0, wrap=0, last-active=DIRECT.
REQ-028 Reset mid-scan SHALL discard progress; next SCAN entry starts at scan_idx=0.
REQ-029 Outputs SHALL hold reset values for every cycle rst is high.

Verification (SEL_W=3, DWELL=2 unless stated)
REQ-030 Direct sweep: en=1, mode=0, in_valid=1, sel=0..7 one per cycle -> next cycle out=0x01,0x02,...,0x80, out_valid=1.
REQ-031 Disable: en=0 with sel=5 -> out=0x00, out_valid=0 next cycle; en=1, in_valid=0 -> out stays 0x00 until in_valid.
REQ-032 Scan: en=1, mode=1 for 17 cycles -> out 0x01,0x01,0x02,0x02,...,0x80,0x80,0x01; wrap=1 only on the 17th cycle.
REQ-033 Pause/resume: scan to scan_idx=3 dwell=1, en=0 for 5 cycles (out=0), en=1 -> out=0x08 for 1 cycle then 0x10.
REQ-034 Reset mid-scan at scan_idx=6, then en=1, mode=1 -> out=0x01, scan_idx=0, wrap=0.
REQ-035 DWELL=1, SEL_W=2: scan 5 cycles -> out 0x1,0x2,0x4,0x8,0x1; wrap=1 on the 5th.
